alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Upstream command sequencer for the 8-bit ALU datapath. It accepts operation commands over a valid/ready handshake and buffers them in a small FIFO. It issues one command at a time to the ALU by driving its operand inputs, the one-hot input selector (persist/load/reset) and the one-hot output selector. After each issue it samples the ALU overflow flag, and it halts issue on overflow until software clears the error.

## Interface
Parameters:
- WIDTH, 8, operand width (matches ALU datapath)
- DEPTH, 4, command FIFO depth (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer accepts command this cycle
- cmd_op  in  3  0 AND, 1 OR, 2 NOT, 3 XOR, 4 ADD, 5 SUB, 6 MULT, 7 CLEAR
- cmd_load  in  1  1 = load cmd_a into accumulator; 0 = persist accumulator
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- alu_error  in  1  ALU overflow flag
- err_clear  in  1  leave HALT, flush FIFO
- num1  out  WIDTH  to ALU operand-1 path
- num2  out  WIDTH  to ALU operand-2 path
- in_selector  out  3  one-hot: [2] persist, [1] load, [0] reset
- out_selector  out  7  one-hot: [6] AND, [5] OR, [4] NOT, [3] XOR, [2] ADD, [1] SUB, [0] MULT
- issue_valid  out  1  high in the cycle a command is presented to the ALU
- busy  out  1  state ≠ IDLE or FIFO non-empty
- err_sticky  out  1  high while in HALT
- err_count  out  8  saturating count of overflow events

## Operation
- FIFO:
  - Holds {op, load, a, b}; count ranges 0..DEPTH.
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = (count < DEPTH) && state ≠ HALT.
  - Pop only on the IDLE→ISSUE or CHECK→ISSUE transition.
  - At most one push and one pop per cycle; count is unchanged when both occur.
- States: IDLE, ISSUE, CHECK, HALT.
  - IDLE: if the FIFO is non-empty, pop the head, register the outputs, and go to ISSUE.
  - ISSUE (one cycle): outputs hold the popped command with issue_valid = 1; go to CHECK.
  - CHECK (one cycle): outputs return to idle values and alu_error is sampled.
    - If alu_error = 1 and the issued op ≠ CLEAR: go to HALT and increment err_count, saturating at 255.
    - Otherwise, if the FIFO is non-empty: pop and go to ISSUE.
    - Otherwise: go to IDLE.
  - HALT: outputs hold idle values and err_sticky = 1. When err_clear = 1, flush the FIFO (count ← 0) and go to IDLE. Pushes are blocked in HALT.
- Output encoding for an issued command:
  - Arithmetic/logic op: num1 = a, num2 = b, out_selector = one-hot per the op mapping above, in_selector = load ? 3'b010 : 3'b100.
  - CLEAR: in_selector = 3'b001, out_selector = 0, num1 = num2 = 0; alu_error is ignored in the following CHECK.
- Idle output values (IDLE, CHECK, HALT): num1 = num2 = 0, out_selector = 0, in_selector = 3'b100, issue_valid = 0.
- err_clear is ignored outside HALT.
- rst has priority over everything else.

## Timing
- All outputs are registered except cmd_ready and busy, which are combinational from registered state only.
- Reset values:
  - in_selector = 3'b001, which drives the ALU reset for the reset cycle.
  - out_selector = 0, num1 = num2 = 0, issue_valid = 0, err_sticky = 0, err_count = 0.
  - FIFO empty, state IDLE.
- In the first cycle after rst deasserts, in_selector is 3'b001 (registered reset value). It becomes 3'b100 from the next cycle.
- Latency, for a command accepted in cycle t into an empty FIFO with state IDLE:
  - issue_valid = 1 in cycle t+2.
  - alu_error is sampled in cycle t+3.
  - The next issue can occur at t+4 at the earliest.
- Sustained throughput: one command per 2 cycles (ISSUE, CHECK alternating).
- FIFO full: cmd_ready = 0. A pop in cycle c re-raises cmd_ready in cycle c+1.
- An error in CHECK blocks cmd_ready from the next cycle. A command pushed in that same CHECK cycle is retained until err_clear flushes it.
- Mid-operation rst: the next edge returns every register to its reset value regardless of state. In-flight and queued commands are discarded.

## Test plan
- Reset then single command: push {ADD, load = 1, a = 8'h12, b = 8'h05} at cycle 0 → cycle 2 shows issue_valid = 1, num1 = 8'h12, num2 = 8'h05, in_selector = 3'b010, out_selector = 7'b0000100. Cycle 3 shows idle values.
- Back-to-back: hold cmd_valid for AND, OR, XOR, MULT (alu_error = 0) → issue_valid pulses in cycles 2, 4, 6, 8; out_selector = 1000000, 0100000, 0001000, 0000001 in that order.
- FIFO full: stall issue with a pending error scenario, push 4 commands → cmd_ready = 0 after the 4th; a 5th push is held off and its data is not lost once ready returns.
- Overflow halt: issue MULT a = 8'hFF, b = 8'h02 with alu_error = 1 in CHECK → err_sticky = 1, err_count = 1, cmd_ready = 0, queued commands not issued. Pulse err_clear → IDLE, FIFO empty, cmd_ready = 1.
- CLEAR op with alu_error = 1 forced → in_selector = 3'b001 during ISSUE, no HALT, err_count unchanged.
- rst asserted during ISSUE with 3 commands queued → next cycle all outputs at reset values, busy = 0, count = 0. err_count saturation: 256 forced errors → err_count stays 255.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Command/issue bundle between a command source, the sequencer and the 8-bit ALU datapath.
// The master drives commands and ALU status; the slave (sequencer) drives ALU controls.
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic             cmd_load;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             alu_error;
    logic             err_clear;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic [2:0]       in_selector;
    logic [6:0]       out_selector;
    logic             issue_valid;
    logic             busy;
    logic             err_sticky;
    logic [7:0]       err_count;

    modport master (
        output cmd_valid, cmd_op, cmd_load, cmd_a, cmd_b, alu_error, err_clear,
        input  cmd_ready, num1, num2, in_selector, out_selector,
        input  issue_valid, busy, err_sticky, err_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_load, cmd_a, cmd_b, alu_error, err_clear,
        output cmd_ready, num1, num2, in_selector, out_selector,
        output issue_valid, busy, err_sticky, err_count
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a FIFO and issues them one at a time (ISSUE/CHECK pairs),
// halting on ALU overflow until software clears the error and flushes the queue.
module alu_cmd_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_sequencer_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [2:0]       OP_CLEAR  = 3'd7;
    localparam logic [2:0]       IN_RESET  = 3'b001;
    localparam logic [2:0]       IN_LOAD   = 3'b010;
    localparam logic [2:0]       IN_PERSIST = 3'b100;

    typedef enum logic [1:0] {IDLE, ISSUE, CHECK, HALT} state_t;

    typedef struct packed {
        logic [2:0]       op;
        logic             load;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    state_t           state_q, state_d;
    cmd_t             fifo_q [DEPTH];
    cmd_t             cmd_in;
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] num1_q, num1_d;
    logic [WIDTH-1:0] num2_q, num2_d;
    logic [2:0]       in_sel_q, in_sel_d;
    logic [6:0]       out_sel_q, out_sel_d;
    logic             issue_q, issue_d;
    logic             err_sticky_q, err_sticky_d;
    logic [7:0]       err_count_q, err_count_d;
    logic             push, pop, flush;
    logic             fifo_empty, fifo_full;

    function automatic logic [6:0] out_onehot(input logic [2:0] op);
        out_onehot = (op == OP_CLEAR) ? 7'd0 : (7'b1000000 >> op);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign cmd_in     = {bus.cmd_op, bus.cmd_load, bus.cmd_a, bus.cmd_b};
    assign head       = fifo_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign push       = bus.cmd_valid && bus.cmd_ready;

    assign bus.cmd_ready    = !fifo_full && (state_q != HALT);
    assign bus.busy         = (state_q != IDLE) || !fifo_empty;
    assign bus.num1         = num1_q;
    assign bus.num2         = num2_q;
    assign bus.in_selector  = in_sel_q;
    assign bus.out_selector = out_sel_q;
    assign bus.issue_valid  = issue_q;
    assign bus.err_sticky   = err_sticky_q;
    assign bus.err_count    = err_count_q;

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        flush       = 1'b0;
        op_d        = op_q;
        num1_d      = '0;
        num2_d      = '0;
        in_sel_d    = IN_PERSIST;
        out_sel_d   = '0;
        issue_d     = 1'b0;
        err_count_d = err_count_q;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = CHECK;
            CHECK: begin
                // A CLEAR resets the accumulator, so any overflow flag seen after it is stale.
                if (bus.alu_error && (op_q != OP_CLEAR)) begin
                    state_d     = HALT;
                    err_count_d = sat_inc(err_count_q);
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                if (bus.err_clear) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            op_d    = head.op;
            issue_d = 1'b1;
            if (head.op == OP_CLEAR) begin
                in_sel_d = IN_RESET;
            end else begin
                num1_d    = head.a;
                num2_d    = head.b;
                out_sel_d = out_onehot(head.op);
                in_sel_d  = head.load ? IN_LOAD : IN_PERSIST;
            end
        end

        err_sticky_d = (state_d == HALT);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            op_q         <= '0;
            num1_q       <= '0;
            num2_q       <= '0;
            in_sel_q     <= IN_RESET;
            out_sel_q    <= '0;
            issue_q      <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            op_q         <= op_d;
            num1_q       <= num1_d;
            num2_q       <= num2_d;
            in_sel_q     <= in_sel_d;
            out_sel_q    <= out_sel_d;
            issue_q      <= issue_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    // Queue storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= cmd_in;
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the sequencer's issue/halt rules.
module tb_alu_cmd_sequencer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0] op;
        logic       ld;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.WIDTH(WIDTH)) bus ();
    alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   vectors = 0;
    int   miscompares = 0;
    cmd_t mq[$];
    cmd_t cur;
    bit   m_iss, m_chk, m_halt, m_rst_prev;
    int   m_errcnt, raw_err, m_pushes, obs_issues;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_osel(input logic [2:0] op);
        case (op)
            3'd0: return 7'b1000000;
            3'd1: return 7'b0100000;
            3'd2: return 7'b0010000;
            3'd3: return 7'b0001000;
            3'd4: return 7'b0000100;
            3'd5: return 7'b0000010;
            3'd6: return 7'b0000001;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_iss = 0; m_chk = 0; m_halt = 0; m_errcnt = 0; m_rst_prev = 1;
    endtask

    // Check this cycle's outputs against the model, then advance model and clock one cycle.
    task automatic cyc();
        logic [2:0] e_in;
        logic [6:0] e_out;
        logic [7:0] e_n1, e_n2;
        bit acc, err_halt, nxt;
        e_in = m_rst_prev ? 3'b001 : 3'b100;
        e_out = '0; e_n1 = '0; e_n2 = '0;
        if (m_iss) begin
            if (cur.op == 3'd7) e_in = 3'b001;
            else begin
                e_in = cur.ld ? 3'b010 : 3'b100;
                e_out = exp_osel(cur.op);
                e_n1 = cur.a; e_n2 = cur.b;
            end
        end
        chk("issue_valid", bus.issue_valid, m_iss);
        chk("num1", bus.num1, e_n1);
        chk("num2", bus.num2, e_n2);
        chk("in_selector", bus.in_selector, e_in);
        chk("out_selector", bus.out_selector, e_out);
        chk("err_sticky", bus.err_sticky, m_halt);
        chk("err_count", bus.err_count, m_errcnt);
        chk("cmd_ready", bus.cmd_ready, (mq.size() < DEPTH) && !m_halt);
        chk("busy", bus.busy, m_iss || m_chk || m_halt || (mq.size() != 0));
        obs_issues += int'(bus.issue_valid);
        if (rst) begin
            model_reset();
        end else begin
            acc      = bus.cmd_valid && (mq.size() < DEPTH) && !m_halt;
            err_halt = m_chk && bus.alu_error && (cur.op != 3'd7);
            nxt      = !m_iss && !m_halt && !err_halt && (mq.size() != 0);
            if (nxt) cur = mq.pop_front();
            if (acc) begin
                mq.push_back('{bus.cmd_op, bus.cmd_load, bus.cmd_a, bus.cmd_b});
                m_pushes++;
            end
            if (m_halt && bus.err_clear) begin
                m_halt = 0;
                mq.delete();
            end
            if (err_halt) begin
                m_halt = 1;
                raw_err++;
                if (m_errcnt < 255) m_errcnt++;
            end
            m_chk = m_iss;
            m_iss = nxt;
            m_rst_prev = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cmd(input bit allow_clear);
        bus.cmd_op   = allow_clear ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 6));
        bus.cmd_load = 1'($urandom_range(0, 1));
        bus.cmd_a    = 8'($urandom);
        bus.cmd_b    = 8'($urandom);
    endtask

    task automatic idle(input int n);
        bus.cmd_valid = 0; bus.alu_error = 0; bus.err_clear = 0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    logic [2:0] b2b_ops [4] = '{3'd0, 3'd1, 3'd3, 3'd6};
    logic [6:0] b2b_sel [4] = '{7'b1000000, 7'b0100000, 7'b0001000, 7'b0000001};

    initial begin
        bit found;
        int saw_full;
        rst = 1;
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_load = 0; bus.cmd_a = 0; bus.cmd_b = 0;
        bus.alu_error = 0; bus.err_clear = 0;
        raw_err = 0; m_pushes = 0; obs_issues = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_in_sel", bus.in_selector, 3'b001);
        chk("rst_busy", bus.busy, 0);
        cyc();

        // Single ADD right after reset
        rst = 0;
        bus.cmd_valid = 1; bus.cmd_op = 3'd4; bus.cmd_load = 1; bus.cmd_a = 8'h12; bus.cmd_b = 8'h05;
        chk("post_rst_in_sel", bus.in_selector, 3'b001);
        cyc();
        bus.cmd_valid = 0;
        chk("t1_c1_insel", bus.in_selector, 3'b100);
        cyc();
        chk("t1_issue", bus.issue_valid, 1);
        chk("t1_num1", bus.num1, 8'h12);
        chk("t1_num2", bus.num2, 8'h05);
        chk("t1_insel", bus.in_selector, 3'b010);
        chk("t1_osel", bus.out_selector, 7'b0000100);
        cyc();
        chk("t1_c3_issue", bus.issue_valid, 0);
        chk("t1_c3_osel", bus.out_selector, 7'b0);
        idle(3);

        // Back-to-back AND, OR, XOR, MULT
        for (int c = 0; c < 10; c++) begin
            if (c < 4) begin
                bus.cmd_valid = 1; bus.cmd_op = b2b_ops[c]; bus.cmd_load = 1;
                bus.cmd_a = 8'(c + 1); bus.cmd_b = 8'(c + 16);
            end else bus.cmd_valid = 0;
            if (c >= 2 && c % 2 == 0) begin
                chk("b2b_issue", bus.issue_valid, 1);
                chk("b2b_osel", bus.out_selector, b2b_sel[(c - 2) / 2]);
            end else chk("b2b_gap", bus.issue_valid, 0);
            cyc();
        end
        idle(3);

        // Sustained pushes fill the FIFO; held commands must survive back-pressure
        m_pushes = 0; obs_issues = 0; saw_full = 0;
        bus.cmd_valid = 1; rand_cmd(0);
        for (int k = 0; k < 40; k++) begin
            found = (mq.size() < DEPTH) && !m_halt;
            if (!bus.cmd_ready) saw_full++;
            cyc();
            if (found) rand_cmd(0);
        end
        chk("full_seen", saw_full > 0, 1);
        idle(12);
        chk("all_issued", obs_issues, m_pushes);
        chk("drained_busy", bus.busy, 0);

        // Overflow on MULT halts issue until err_clear
        bus.alu_error = 1;
        bus.cmd_valid = 1; bus.cmd_op = 3'd6; bus.cmd_load = 1; bus.cmd_a = 8'hFF; bus.cmd_b = 8'h02;
        cyc();
        bus.cmd_op = 3'd0; bus.cmd_a = 8'h0F;
        cyc();
        bus.cmd_op = 3'd1;
        chk("ovf_issue", bus.issue_valid, 1);
        chk("ovf_num1", bus.num1, 8'hFF);
        chk("ovf_osel", bus.out_selector, 7'b0000001);
        cyc();
        bus.cmd_op = 3'd3;
        chk("ovf_check_ready", bus.cmd_ready, 1);
        cyc();
        chk("ovf_sticky", bus.err_sticky, 1);
        chk("ovf_count", bus.err_count, 1);
        chk("ovf_ready", bus.cmd_ready, 0);
        for (int k = 0; k < 3; k++) cyc();
        bus.cmd_valid = 0; bus.err_clear = 1;
        cyc();
        bus.err_clear = 0; bus.alu_error = 0;
        chk("clr_busy", bus.busy, 0);
        chk("clr_ready", bus.cmd_ready, 1);
        chk("clr_sticky", bus.err_sticky, 0);
        idle(3);

        // CLEAR ignores overflow flag
        bus.alu_error = 1;
        bus.cmd_valid = 1; bus.cmd_op = 3'd7; bus.cmd_load = 0; bus.cmd_a = 8'h55; bus.cmd_b = 8'h66;
        cyc();
        bus.cmd_valid = 0;
        cyc();
        chk("clr_op_insel", bus.in_selector, 3'b001);
        chk("clr_op_num1", bus.num1, 8'h00);
        cyc();
        cyc();
        chk("clr_op_nohalt", bus.err_sticky, 0);
        chk("clr_op_errcnt", bus.err_count, 1);
        idle(2);

        // Reset during ISSUE with commands queued
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (m_iss && mq.size() >= 3) found = 1;
            else begin
                bus.cmd_valid = 1; rand_cmd(0);
                cyc();
            end
        end
        chk("rst_setup", found, 1);
        rst = 1; bus.cmd_valid = 0;
        cyc();
        rst = 0;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_insel", bus.in_selector, 3'b001);
        chk("mid_rst_errcnt", bus.err_count, 0);
        chk("mid_rst_ready", bus.cmd_ready, 1);
        cyc();
        chk("mid_rst_busy2", bus.busy, 0);
        idle(2);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            bus.cmd_valid = ($urandom_range(0, 9) < 7);
            rand_cmd(1);
            bus.alu_error = ($urandom_range(0, 3) == 0);
            bus.err_clear = ($urandom_range(0, 2) == 0);
            cyc();
        end
        bus.err_clear = 1;
        idle(6);

        // err_count saturation
        raw_err = 0;
        bus.cmd_valid = 1; bus.cmd_op = 3'd6; bus.cmd_load = 1; bus.cmd_a = 8'hFF; bus.cmd_b = 8'hFF;
        bus.alu_error = 1; bus.err_clear = 1;
        for (int k = 0; k < 3000 && raw_err < 270; k++) cyc();
        chk("sat_reached", raw_err >= 270, 1);
        chk("sat_count", bus.err_count, 8'd255);
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
